// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, default memory geometry, port index constants.
package dmem_arbiter_pkg;

  // Default geometry: 32 words of 64 bits.
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 64;

  // Port indices into one-hot grant vectors.
  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  // IDLE arbitrates and accesses; RMW is the write-back half of a partial write.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick between port 0 and port 1.
// Latency: combinational.
// Backpressure: none; a non-requesting port is never picked.
// Ports: req0_i/req1_i requests, last_i last granted port, gnt_o one-hot pick.
module dmem_rr_pick (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req0_i && req1_i) begin
      // Contention: favour the port that was not served last.
      gnt_o = last_i ? 2'b01 : 2'b10;
    end else if (req0_i) begin
      gnt_o = 2'b01;
    end else if (req1_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Latency: grant combinational in the request cycle; read data/valid one cycle after grant.
// Backpressure: a requester holds its request until it sees its GNT; no grant during RMW.
// Ports: CLK/RST_N; per port n: REQn, WEn, ADDRn, WDATAn, (BEn), GNTn, RVALIDn, RDATAn;
//        memory side: MEM_ADDR, MEM_WE, MEM_DIN, MEM_DOUT (combinational read).
// Build option: DMEM_ARB_BYTE_WRITE_EN adds BE ports and read-modify-write partial writes.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                REQ0,
  input  logic                REQ1,
  input  logic                WE0,
  input  logic                WE1,
  input  logic [ADDR_W-1:0]   ADDR0,
  input  logic [ADDR_W-1:0]   ADDR1,
  input  logic [DATA_W-1:0]   WDATA0,
  input  logic [DATA_W-1:0]   WDATA1,
`ifdef DMEM_ARB_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] BE0,
  input  logic [DATA_W/8-1:0] BE1,
`endif
  output logic                GNT0,
  output logic                GNT1,
  output logic                RVALID0,
  output logic                RVALID1,
  output logic [DATA_W-1:0]   RDATA0,
  output logic [DATA_W-1:0]   RDATA1,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic                MEM_WE,
  output logic [DATA_W-1:0]   MEM_DIN,
  input  logic [DATA_W-1:0]   MEM_DOUT
);

  arb_state_t        state_q;
  logic              last_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic [1:0]        pick;
  logic              idle_act;
  logic              rmw_act;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              full_wr;
  logic              part_wr;

  dmem_rr_pick u_pick (
    .req0_i (REQ0),
    .req1_i (REQ1),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  // Grants only while out of reset and in IDLE.
  assign idle_act = RST_N && (state_q == ST_IDLE);
  assign GNT0     = idle_act && pick[PORT0];
  assign GNT1     = idle_act && pick[PORT1];
  assign any_gnt  = GNT0 || GNT1;

  assign sel_we    = GNT1 ? WE1    : WE0;
  assign sel_addr  = GNT1 ? ADDR1  : ADDR0;
  assign sel_wdata = GNT1 ? WDATA1 : WDATA0;

`ifdef DMEM_ARB_BYTE_WRITE_EN
  localparam int BE_W = DATA_W / 8;

  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] merge_q;
  logic [ADDR_W-1:0] rmw_addr_q;

  assign sel_be = GNT1 ? BE1 : BE0;

  // All-ones is a plain write; all-zeros is granted but writes nothing.
  assign full_wr = any_gnt && sel_we && (&sel_be);
  assign part_wr = any_gnt && sel_we && !(&sel_be) && (|sel_be);

  // The write-back cycle is dropped if reset arrives during it.
  assign rmw_act = RST_N && (state_q == ST_RMW);

  // Current memory word with the enabled bytes overlaid by the write data.
  always_comb begin
    merged = MEM_DOUT;
    for (int b = 0; b < BE_W; b++) begin
      if (sel_be[b]) merged[b*8 +: 8] = sel_wdata[b*8 +: 8];
    end
  end

  assign MEM_ADDR = rmw_act ? rmw_addr_q : (any_gnt ? sel_addr : '0);
  assign MEM_WE   = full_wr || rmw_act;
  assign MEM_DIN  = rmw_act ? merge_q : (full_wr ? sel_wdata : '0);
`else
  assign full_wr  = any_gnt && sel_we;
  assign part_wr  = 1'b0;
  assign rmw_act  = 1'b0;

  assign MEM_ADDR = any_gnt ? sel_addr : '0;
  assign MEM_WE   = full_wr;
  assign MEM_DIN  = full_wr ? sel_wdata : '0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifdef DMEM_ARB_BYTE_WRITE_EN
      merge_q    <= '0;
      rmw_addr_q <= '0;
`endif
    end else begin
      // Read data is the memory output sampled at the end of the grant cycle.
      rvalid0_q <= GNT0 && !WE0;
      rvalid1_q <= GNT1 && !WE1;
      if (GNT0 && !WE0) rdata0_q <= MEM_DOUT;
      if (GNT1 && !WE1) rdata1_q <= MEM_DOUT;

      if (any_gnt) last_q <= GNT1;

      case (state_q)
        ST_IDLE: begin
          if (part_wr) begin
            state_q    <= ST_RMW;
`ifdef DMEM_ARB_BYTE_WRITE_EN
            merge_q    <= merged;
            rmw_addr_q <= sel_addr;
`endif
          end
        end
        ST_RMW:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign RVALID0 = rvalid0_q;
  assign RVALID1 = rvalid1_q;
  assign RDATA0  = rdata0_q;
  assign RDATA1  = rdata1_q;

  // rmw_act is only consulted in byte-write builds.
  logic unused_ok;
  assign unused_ok = rmw_act;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: bench-side memory, reference memory and per-port
// expected-read queues; a monitor checks grants, memory-side signals and read returns.
module tb_dmem_arbiter;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int BW = DW / 8;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          REQ0, REQ1, WE0, WE1;
  logic [AW-1:0] ADDR0, ADDR1;
  logic [DW-1:0] WDATA0, WDATA1;
  logic [BW-1:0] BE0, BE1;
  logic          GNT0, GNT1, RVALID0, RVALID1;
  logic [DW-1:0] RDATA0, RDATA1;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_WE;
  logic [DW-1:0] MEM_DIN, MEM_DOUT;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
`ifdef DMEM_ARB_BYTE_WRITE_EN
    .BE0(BE0), .BE1(BE1),
`endif
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
    .RDATA0(RDATA0), .RDATA1(RDATA1),
    .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
  );

  // Bench data memory: combinational read, write on the rising edge.
  logic [DW-1:0] mem [32];
  logic          mem_clr = 1'b1;
  logic          pre_vld = 1'b0;
  logic [AW-1:0] pre_a   = '0;
  logic [DW-1:0] pre_d   = '0;
  assign MEM_DOUT = mem[MEM_ADDR];
  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (MEM_WE) begin
      mem[MEM_ADDR] <= MEM_DIN;
    end else if (pre_vld) begin
      mem[pre_a] <= pre_d;
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            gnt_log[$];
  int            checks = 0;
  int            passes = 0;
  logic          mon_en = 1'b0;
  logic          last_gnt, pend0, pend1, in_rmw;
  logic [AW-1:0] rmw_addr;
  logic [DW-1:0] rmw_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    checks++;
    $display("FAIL %s: wait budget expired, got no grant expected grant", nm);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_d, input logic [DW-1:0] new_d,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_d;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
    return r;
  endfunction

  // One monitor step per falling edge.
  task automatic mon_cycle();
    logic eg0, eg1, sw, full, part;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    logic [BW-1:0] sb;
    chk("rvalid0", RVALID0, pend0);
    chk("rvalid1", RVALID1, pend1);
    if (pend0) begin
      if (exp_q0.size() == 0) fail_now("rdata0_unexpected");
      else chk("rdata0", RDATA0, exp_q0.pop_front());
    end
    if (pend1) begin
      if (exp_q1.size() == 0) fail_now("rdata1_unexpected");
      else chk("rdata1", RDATA1, exp_q1.pop_front());
    end
    if (GNT0 || GNT1) gnt_log.push_back(GNT1 ? 1 : 0);
    pend0 = 1'b0;
    pend1 = 1'b0;
    if (!RST_N) begin
      chk("rst_gnt0", GNT0, 0);
      chk("rst_gnt1", GNT1, 0);
      chk("rst_mem_we", MEM_WE, 0);
      last_gnt = 1'b1;
      in_rmw   = 1'b0;
    end else if (in_rmw) begin
      chk("rmw_gnt0", GNT0, 0);
      chk("rmw_gnt1", GNT1, 0);
      chk("rmw_we", MEM_WE, 1);
      chk("rmw_addr", MEM_ADDR, rmw_addr);
      chk("rmw_din", MEM_DIN, rmw_data);
      in_rmw = 1'b0;
    end else begin
      if (REQ0 && REQ1) begin
        eg0 = last_gnt;
        eg1 = !last_gnt;
      end else begin
        eg0 = REQ0;
        eg1 = REQ1;
      end
      chk("gnt0", GNT0, eg0);
      chk("gnt1", GNT1, eg1);
      if (eg0 || eg1) begin
        sw = eg1 ? WE1 : WE0;
        sa = eg1 ? ADDR1 : ADDR0;
        sd = eg1 ? WDATA1 : WDATA0;
        sb = eg1 ? BE1 : BE0;
        full = sw && (&sb);
        part = sw && (|sb) && !(&sb);
        chk("mem_addr", MEM_ADDR, sa);
        chk("mem_we", MEM_WE, full);
        chk("mem_din", MEM_DIN, full ? sd : '0);
        pend0 = eg0 && !sw;
        pend1 = eg1 && !sw;
        last_gnt = eg1;
        if (part) begin
          in_rmw   = 1'b1;
          rmw_addr = sa;
          rmw_data = merge(mem[sa], sd, sb);
        end
      end else begin
        chk("idle_mem_we", MEM_WE, 0);
        chk("idle_mem_addr", MEM_ADDR, 0);
        chk("idle_mem_din", MEM_DIN, 0);
      end
    end
  endtask

  initial begin
    wait (mon_en);
    forever begin
      @(negedge CLK);
      mon_cycle();
    end
  end

  // Issue one request on port p and hold it until granted.
  task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    int   n;
    logic g;
    if (we) ref_mem[a] = merge(ref_mem[a], d, be);
    else if (p == 0) exp_q0.push_back(ref_mem[a]);
    else exp_q1.push_back(ref_mem[a]);
    if (p == 0) begin
      REQ0 = 1'b1; WE0 = we; ADDR0 = a; WDATA0 = d; BE0 = be;
    end else begin
      REQ1 = 1'b1; WE1 = we; ADDR1 = a; WDATA1 = d; BE1 = be;
    end
    n = 0;
    g = 1'b0;
    while (!g && n < 40) begin
      @(negedge CLK);
      n++;
      g = (p == 0) ? GNT0 : GNT1;
    end
    if (!g) fail_now((p == 0) ? "grant_wait0" : "grant_wait1");
    @(posedge CLK);
    #1;
    if (p == 0) REQ0 = 1'b0;
    else REQ1 = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_vld = 1'b1; pre_a = a; pre_d = d;
    ref_mem[a] = d;
    @(posedge CLK);
    #1;
    pre_vld = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    last_gnt = 1'b1; pend0 = 1'b0; pend1 = 1'b0; in_rmw = 1'b0;
    rmw_addr = '0; rmw_data = '0;
    RST_N = 1'b0;
    REQ0 = 1'b1; REQ1 = 1'b1; WE0 = 1'b1; WE1 = 1'b0;
    ADDR0 = 5'd1; ADDR1 = 5'd2; WDATA0 = 64'hDEAD; WDATA1 = '0;
    BE0 = '1; BE1 = '1;

    // Requests held high through reset must not be granted.
    repeat (2) begin
      @(negedge CLK);
      chk("reset_gnt0", GNT0, 0);
      chk("reset_gnt1", GNT1, 0);
      chk("reset_mem_we", MEM_WE, 0);
    end
    step();
    chk("reset_rvalid0", RVALID0, 0);
    chk("reset_rvalid1", RVALID1, 0);
    chk("reset_rdata0", RDATA0, 0);
    chk("reset_rdata1", RDATA1, 0);
    REQ0 = 1'b0; REQ1 = 1'b0;
    mem_clr = 1'b0;
    RST_N = 1'b1;
    mon_en = 1'b1;

    // Both ports read back to back straight after reset: 0,1,0,1.
    gnt_log.delete();
    fork
      begin issue(0, 1'b0, 5'd0, '0, '1); issue(0, 1'b0, 5'd1, '0, '1); end
      begin issue(1, 1'b0, 5'd16, '0, '1); issue(1, 1'b0, 5'd17, '0, '1); end
    join
    step();
    chk("order_len", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
      chk("order_0", gnt_log[0], 0);
      chk("order_1", gnt_log[1], 1);
      chk("order_2", gnt_log[2], 0);
      chk("order_3", gnt_log[3], 1);
    end

    // Port 0 writes 150 to word 11 and reads it back.
    issue(0, 1'b1, 5'd11, 64'd150, '1);
    issue(0, 1'b0, 5'd11, '0, '1);
    step();
    chk("wr_rd_mem11", mem[11], 64'd150);

    // LAST=0: simultaneous port-1 write and port-0 read, port 1 served first.
    gnt_log.delete();
    fork
      issue(1, 1'b1, 5'd11, 64'd300, '1);
      issue(0, 1'b0, 5'd3, '0, '1);
    join
    step();
    chk("contend_len", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("contend_first", gnt_log[0], 1);
      chk("contend_second", gnt_log[1], 0);
    end
    chk("contend_mem11", mem[11], 64'd300);

`ifdef DMEM_ARB_BYTE_WRITE_EN
    // Partial write; port 1 arrives during the write-back cycle and must wait.
    preload(5'd5, 64'h1111_2222_3333_4444);
    gnt_log.delete();
    fork
      issue(0, 1'b1, 5'd5, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
      begin step(); issue(1, 1'b0, 5'd20, '0, '1); end
    join
    step();
    chk("rmw_mem5", mem[5], 64'h1111_2222_AAAA_AAAA);
    chk("rmw_order_len", gnt_log.size(), 2);
    if (gnt_log.size() == 2) chk("rmw_order_1", gnt_log[1], 1);

    // Reset in the write-back cycle abandons the write.
    preload(5'd6, 64'h0123_4567_89AB_CDEF);
    issue(0, 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    ref_mem[6] = 64'h0123_4567_89AB_CDEF;
    chk("rmw_abort_mem6", mem[6], 64'h0123_4567_89AB_CDEF);

    // Empty byte enable: granted, nothing written.
    preload(5'd7, 64'h7777_0000_7777_0000);
    issue(0, 1'b1, 5'd7, 64'h5555_5555_5555_5555, 8'h00);
    step();
    chk("be0_mem7", mem[7], 64'h7777_0000_7777_0000);
`endif

    // Random traffic, port 0 on words 0..15, port 1 on words 16..31.
    fork
      for (int i = 0; i < 40; i++) begin
        logic [BW-1:0] be;
        be = '1;
`ifdef DMEM_ARB_BYTE_WRITE_EN
        if ($urandom_range(0, 2) == 0) be = BW'($urandom);
`endif
        repeat ($urandom_range(0, 2)) step();
        issue(0, 1'($urandom), AW'($urandom_range(0, 15)), {$urandom, $urandom}, be);
      end
      for (int j = 0; j < 40; j++) begin
        logic [BW-1:0] be;
        be = '1;
`ifdef DMEM_ARB_BYTE_WRITE_EN
        if ($urandom_range(0, 2) == 0) be = BW'($urandom);
`endif
        repeat ($urandom_range(0, 2)) step();
        issue(1, 1'($urandom), AW'($urandom_range(16, 31)), {$urandom, $urandom}, be);
      end
    join

    repeat (4) step();
    for (int k = 0; k < 32; k++) chk($sformatf("final_mem%0d", k), mem[k], ref_mem[k]);
    chk("exp0_drained", exp_q0.size(), 0);
    chk("exp1_drained", exp_q1.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, sets the data memory word-address width (32 words).
REQ-002 Parameter DATA_W, default 64, sets the data memory word width.
REQ-003 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  synchronous, active-low reset.
REQ-005 REQ0/REQ1  input  1 each  access request from port 0 (core load/store) and port 1 (debug/DMA).
REQ-006 WE0/WE1  input  1 each  request is a write (1) or a read (0).
REQ-007 ADDR0/ADDR1  input  ADDR_W each  word address of the request.
REQ-008 WDATA0/WDATA1  input  DATA_W each  write data.
REQ-009 BE0/BE1  input  DATA_W/8 each  byte enables; present only with DMEM_ARB_BYTE_WRITE_EN.
REQ-010 GNT0/GNT1  output  1 each  request accepted this cycle (combinational).
REQ-011 RVALID0/RVALID1  output  1 each  read data valid, registered.
REQ-012 RDATA0/RDATA1  output  DATA_W each  read data, registered.
REQ-013 MEM_ADDR  output  ADDR_W  datamemory ADDR.
REQ-014 MEM_WE  output  1  datamemory WE; the memory writes on the CLK rising edge when high.
REQ-015 MEM_DIN  output  DATA_W  datamemory D_in.
REQ-016 MEM_DOUT  input  DATA_W  datamemory D_out; combinational read of MEM_ADDR.

Function
REQ-017 FSM states: IDLE (arbitrate and access); RMW (second cycle of a partial write, macro builds only).
REQ-018 In IDLE, at most one GNT is high per cycle, and only for a port whose REQ is high.
REQ-019 Single requester in IDLE: that port is granted in the same cycle.
REQ-020 Both requesting in IDLE: grant the port not equal to register LAST; LAST updates to the granted port on every grant.
REQ-021 Requesters hold REQ, WE, ADDR, WDATA and BE stable until their GNT is seen; REQ may drop on the granted cycle.
REQ-022 In the granted cycle, MEM_ADDR equals the granted ADDR; otherwise MEM_ADDR equals 0.
REQ-023 A granted full write drives MEM_WE=1 and MEM_DIN=WDATA in the grant cycle.
REQ-024 A granted read drives MEM_WE=0; the next cycle, RDATAn holds the captured MEM_DOUT and RVALIDn=1 for exactly one cycle.
REQ-025 RDATAn holds its value until the next read completes on that port; RVALID of the other port stays 0.
REQ-026 MEM_WE is 0 and MEM_DIN is 0 whenever no write is being issued.
REQ-027 Back-to-back grants are allowed; sustained throughput is one access per cycle in IDLE.

Reset
REQ-028 While RST_N=0 at a rising edge: state becomes IDLE, LAST becomes 1, RVALID0/1 become 0, RDATA0/1 become 0, and the merge buffer becomes 0.
REQ-029 While RST_N=0, GNT0/1 and MEM_WE are 0.
REQ-030 Reset asserted during RMW abandons the write; memory is not modified.

Configuration
REQ-031 Macro DMEM_ARB_BYTE_WRITE_EN compiled in: BE ports exist and partial writes are supported.
REQ-032 With the macro, a write with all BE bits set is a full write per REQ-023.
REQ-033 With the macro, a write with all BE bits clear is granted, completes in one cycle, and leaves MEM_WE=0.
REQ-034 With the macro, any other BE value is a partial write:
  - Grant cycle: MEM_WE=0; buffer latches MEM_DOUT with enabled bytes replaced by WDATA bytes; go to RMW.
  - RMW cycle: MEM_ADDR is the held address; MEM_WE=1; MEM_DIN is the buffer; no GNT; return to IDLE.
REQ-035 Without the macro: no BE ports, no RMW state, and every write is a full write.

Structure
REQ-036 Shared package holds the state encoding (IDLE, RMW), the ADDR_W/DATA_W defaults and the port index constants.
REQ-037 The round-robin pick (inputs REQ0, REQ1, LAST; one-hot output) is a sub-module, dmem_rr_pick.

Verification
REQ-038 Port 0 writes 150 to address 11, then reads address 11 -> GNT0 in each request cycle; RVALID0=1 and RDATA0=150 one cycle after the read grant.
REQ-039 Both ports read continuously for 4 cycles after reset -> grants in order 0,1,0,1; each RVALID follows its grant by one cycle.
REQ-040 Port 1 writes 300 to address 11 while port 0 reads address 3 in the same cycle, with LAST=0 -> port 1 is granted first, port 0 the next cycle; memory[11]=300.
REQ-041 With the macro: memory[5]=0x1111_2222_3333_4444; port 0 writes 0xAAAA_AAAA_AAAA_AAAA with BE=0x0F -> 2 cycles, port 1 is not granted during RMW; memory[5]=0x1111_2222_AAAA_AAAA.
REQ-042 With the macro: RST_N=0 during the RMW cycle -> MEM_WE=0, memory unchanged, IDLE, RVALIDs 0.
REQ-043 Port 0 write with BE=0x00 -> GNT0=1, MEM_WE stays 0, memory unchanged.
